// File: rtl/branch_predict_if.sv
// Fetch-side bus between the branch predictor and its fetch/execute neighbours.
// The slave modport is the predictor; the master modport drives fetch and resolve.
interface branch_predict_if;
    logic [15:0] inst_in;
    logic        inst_valid_in;
    logic        stall_in;
    logic        resolve_valid_in;
    logic        branch_fail_in;
    logic [15:0] PC_o;
    logic [15:0] LBPC_o;
    logic        pred_taken_o;
    logic        flush_o;
    logic        stall_o;

    modport master (
        output inst_in, inst_valid_in, stall_in, resolve_valid_in, branch_fail_in,
        input  PC_o, LBPC_o, pred_taken_o, flush_o, stall_o
    );

    modport slave (
        input  inst_in, inst_valid_in, stall_in, resolve_valid_in, branch_fail_in,
        output PC_o, LBPC_o, pred_taken_o, flush_o, stall_o
    );
endinterface

// File: rtl/branch_predict.sv
// Always-taken fetch predictor for XM23: owns the PC, redirects on BL/Bcc and keeps
// the fall-through PCs of unresolved branches in a FIFO for misprediction recovery.
module branch_predict #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_predict_if.slave bp
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {RUN, FULL, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [15:0]        fifo_q [DEPTH];

    logic               is_branch;
    logic signed [15:0] off_s;
    logic [15:0]        pc_plus2;
    logic [15:0]        target;
    logic               fifo_full;
    logic               stall_full;
    logic               pred_taken;
    logic               fail;
    logic               pop;
    logic               push;

    always_comb begin
        is_branch = bp.inst_valid_in && (bp.inst_in[15:14] == 2'b00);
        if (bp.inst_in[13] == 1'b0)
            off_s = {{2{bp.inst_in[12]}}, bp.inst_in[12:0], 1'b0};
        else
            off_s = {{5{bp.inst_in[9]}}, bp.inst_in[9:0], 1'b0};
        pc_plus2 = pc_q + 16'd2;
        target   = pc_plus2 + $unsigned(off_s);
    end

    // Decode is suppressed during FLUSH: the instruction on inst_in is on the squashed path.
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign stall_full = is_branch && (state_q != FLUSH) && fifo_full;
    assign pred_taken = is_branch && (state_q != FLUSH) && !fifo_full;

    // Resolves arriving with nothing in flight are ignored, including failing ones.
    assign fail = bp.resolve_valid_in && bp.branch_fail_in && (count_q != '0);
    assign pop  = bp.resolve_valid_in && !bp.branch_fail_in && (count_q != '0);
    assign push = pred_taken && !bp.stall_in && !fail;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        unique case (state_q)
            RUN:     if (stall_full && !pop) state_d = FULL;
            FULL:    if (pop) state_d = RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase

        if (fail) begin
            pc_d     = fifo_q[rd_ptr_q];
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = FLUSH;
        end else if ((state_q == FLUSH) || bp.stall_in || stall_full) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = target;
        end else begin
            pc_d = pc_plus2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry contents need no reset; count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= pc_plus2;
    end

    assign bp.PC_o         = pc_q;
    assign bp.LBPC_o       = pc_plus2;
    assign bp.flush_o      = (state_q == FLUSH);
    assign bp.pred_taken_o = pred_taken;
    assign bp.stall_o      = stall_full;
endmodule
